quadrature_decoder: RTL and testbench
=====================================

// Module: quadrature_decoder
// PURPOSE
//  Front end of the incremental-encoder path. Synchronises and de-glitches raw encoder
//  channels A/B and decodes the quadrature Gray sequence into a one-cycle step pulse plus
//  direction. step/dir drive the downstream position counter's enable/dir inputs directly.
//  Flags illegal transitions (both channels changing in one filtered update).
// PARAMETERS
//  FILTER_LEN  4  consecutive mismatching cycles before a filtered channel changes (1..255)
//  RESOLUTION  4  counts per encoder cycle: 1 (X1), 2 (X2) or 4 (X4)
// PORTS
//  clk         in   1  single clock; all logic on the rising edge
//  rst         in   1  synchronous, active-high reset
//  en          in   1  1 = step output enabled; 0 = steps suppressed, tracking continues
//  enc_a       in   1  raw encoder channel A (asynchronous)
//  enc_b       in   1  raw encoder channel B (asynchronous)
//  err_clr     in   1  1-cycle pulse, clears err_sticky
//  step        out  1  1-cycle pulse per counted transition
//  dir         out  1  1 = forward (A leads B), 0 = reverse
//  err         out  1  1-cycle pulse on an illegal transition
//  err_sticky  out  1  latched err, held until err_clr
//  state_ab    out  2  current filtered {A,B}, debug
// BEHAVIOUR
//  Reset: sync flops, filters, filter counters, state_ab, step, dir, err, err_sticky = 0;
//   FSM -> S_INIT. A reset mid-sequence discards all history. No step/err follows release.
//  Sync: two flops per channel. Filter: per channel, counter increments while sync2 != filt
//   and clears on match. At count == FILTER_LEN, filt <= sync2 and counter clears.
//  FSM S_INIT: lasts 3 cycles after rst release (2 to fill sync). On the 3rd edge, filt and
//   prev load from sync2 directly, with no step or err. Then go to S_RUN.
//  FSM S_RUN: each cycle compare cur = filt with prev, then prev <= cur.
//   Forward Gray order {A,B}: 00->10->11->01->00. Reverse order is the inverse.
//   One-bit change: valid. dir <= direction. dir updates on every valid transition,
//    independent of en and RESOLUTION.
//   Two-bit change: err = 1 for one cycle, err_sticky <= 1, step = 0, dir unchanged.
//   No change: step = 0.
//  step = valid & en & counted. Counted transitions by RESOLUTION:
//   4: all valid transitions.
//   2: transitions where A changes (00<->10, 11<->01).
//   1: forward 00->10, reverse 10->00 only.
//  Latency: a pin edge sampled at edge k gives filt updated at edge k+1+FILTER_LEN, and
//   step/dir registered at edge k+2+FILTER_LEN (6 cycles for FILTER_LEN=4).
//  Max trackable rate: one transition per FILTER_LEN+1 cycles. Faster input is undefined,
//   typically reported as err.
//  err_clr and a new err in the same cycle: err_sticky stays 1 (set wins).
//  en=0: prev keeps tracking, so re-enabling never produces a burst or a stale step.
//  All outputs are registered. step is stable across the full clock period.
// STRUCTURE
//  encoder_pkg: FSM state typedef (S_INIT, S_RUN), {A,B} Gray state constants,
//   RES_X1/X2/X4 constants, FILTER_W = $clog2(FILTER_LEN+1) helper.
//  Sub-module glitch_filter (2-flop sync + counter filter), instantiated for A and for B.
//  Top: init FSM, transition decode, resolution gating, error latch.
// TESTING (FILTER_LEN=4, RESOLUTION=4 unless noted; pins start 00, reset 2 cycles)
//  1 Forward 00->10->11->01->00, each held 10 cycles -> 4 step pulses with dir=1, each
//    6 cycles after its pin edge; err=0 throughout.
//  2 Reverse 00->01->11->10->00 -> 4 step pulses with dir=0; state_ab follows the sequence.
//  3 A high for 3 cycles, then low -> no step, state_ab stays 00. A held 4 cycles -> one
//    step, dir=1.
//  4 A and B toggle on the same edge (00->11) -> err=1 for exactly 1 cycle, err_sticky=1,
//    no step. err_clr -> err_sticky=0. err_clr coincident with a new err -> err_sticky=1.
//  5 RESOLUTION=1, full forward cycle -> exactly 1 step (on 00->10). Full reverse cycle ->
//    exactly 1 step (on 10->00), dir=0. RESOLUTION=2 -> 2 steps per cycle.
//  6 en=0 over two forward transitions -> no steps, dir=1. en=1 then one more transition ->
//    exactly 1 step. Reset with pins held 11 -> all outputs 0, no step/err after release,
//    state_ab=11 after 3 cycles.

Source files
------------

// File: rtl/quadrature_decoder_pkg.sv
// Shared types and constants for the quadrature decoder: init FSM states, Gray
// {A,B} codes, resolution selectors and the filter counter width helper.
package quadrature_decoder_pkg;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_01 = 2'b01;

  localparam int RES_X1 = 1;
  localparam int RES_X2 = 2;
  localparam int RES_X4 = 4;

  // Last S_INIT cycle index; the first two cycles let the synchronisers fill.
  localparam logic [1:0] INIT_LAST = 2'd2;

  function automatic int filter_w(input int filter_len);
    return $clog2(filter_len + 1);
  endfunction

  // Successor of an {A,B} code in the forward direction (00->10->11->01->00).
  function automatic logic [1:0] gray_fwd(input logic [1:0] ab);
    logic [1:0] nxt;
    nxt = AB_10;
    case (ab)
      AB_00:   nxt = AB_10;
      AB_10:   nxt = AB_11;
      AB_11:   nxt = AB_01;
      default: nxt = AB_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Encoder pins, control inputs and decoded outputs of one quadrature decoder.
interface quadrature_decoder_if;
  logic       en;
  logic       enc_a;
  logic       enc_b;
  logic       err_clr;
  logic       step;
  logic       dir;
  logic       err;
  logic       err_sticky;
  logic [1:0] state_ab;

  modport master (
    output en, enc_a, enc_b, err_clr,
    input  step, dir, err, err_sticky, state_ab
  );

  modport slave (
    input  en, enc_a, enc_b, err_clr,
    output step, dir, err, err_sticky, state_ab
  );
endinterface

// File: rtl/quadrature_decoder_glitch_filter.sv
// Two-flop synchroniser followed by a persistence filter: the output follows the
// synchronised input only after FILTER_LEN consecutive mismatching cycles.
module glitch_filter
  import quadrature_decoder_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  input  logic active_i,
  input  logic load_i,
  output logic sync_o,
  output logic filt_o
);

  localparam int             CW       = filter_w(FILTER_LEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else if (active_i) begin
      if (sync2_q == filt_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: non-blocking assignments keep flop updates independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_o = sync2_q;
  assign filt_o = filt_q;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder top: de-glitched A/B, start-up FSM, Gray transition decode
// into step/dir, resolution gating and illegal-transition reporting.
module quadrature_decoder
  import quadrature_decoder_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int RESOLUTION = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  quadrature_decoder_if.slave  bus
);

  state_e     state_q, state_d;
  logic [1:0] init_cnt_q, init_cnt_d;
  logic       load, active;
  logic       sync_a, sync_b, filt_a, filt_b;
  logic [1:0] cur, changed;
  logic [1:0] prev_q, prev_d;
  logic       fwd, counted;
  logic       step_q, step_d, dir_q, dir_d, err_q, err_d, sticky_q, sticky_d;

  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .raw_i(bus.enc_a), .active_i(active), .load_i(load),
    .sync_o(sync_a), .filt_o(filt_a)
  );

  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .raw_i(bus.enc_b), .active_i(active), .load_i(load),
    .sync_o(sync_b), .filt_o(filt_b)
  );

  assign cur     = {filt_a, filt_b};
  assign changed = cur ^ prev_q;
  assign fwd     = (cur == gray_fwd(prev_q));
  assign counted = (RESOLUTION == RES_X4) ? 1'b1 :
                   (RESOLUTION == RES_X2) ? changed[1] :
                   ((prev_q == AB_00 && cur == AB_10) || (prev_q == AB_10 && cur == AB_00));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      S_INIT:  if (init_cnt_q == INIT_LAST) state_d = S_RUN;
               else init_cnt_d = init_cnt_q + 2'd1;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  assign load   = (state_q == S_INIT) && (init_cnt_q == INIT_LAST);
  assign active = (state_q == S_RUN);

  always_comb begin
    prev_d   = prev_q;
    step_d   = 1'b0;
    err_d    = 1'b0;
    dir_d    = dir_q;
    sticky_d = sticky_q;
    if (load) begin
      prev_d = {sync_a, sync_b};
    end else if (active) begin
      prev_d = cur;
      if (changed == 2'b11) begin
        err_d = 1'b1;
      end else if (changed != 2'b00) begin
        dir_d  = fwd;
        step_d = bus.en && counted;
      end
    end
    // A new error wins over a simultaneous clear.
    if (err_d)            sticky_d = 1'b1;
    else if (bus.err_clr) sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= AB_00;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.step       = step_q;
  assign bus.dir        = dir_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = sticky_q;
  assign bus.state_ab   = cur;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Drives three decoders (X4, X2, X1) with shared pin stimulus and compares them every
// cycle against a Gray-position reference model, plus directed step/err counts.
module tb_quadrature_decoder;
  import quadrature_decoder_pkg::*;

  localparam int FL   = 4;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst, en, a, b, err_clr;
  logic [NDUT-1:0][5:0] obs;

  always #5 clk = ~clk;

  quadrature_decoder_if bus [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int R = (g == 0) ? 4 : (g == 1) ? 2 : 1;
    assign bus[g].en      = en;
    assign bus[g].enc_a   = a;
    assign bus[g].enc_b   = b;
    assign bus[g].err_clr = err_clr;
    quadrature_decoder #(.FILTER_LEN(FL), .RESOLUTION(R)) u_dut (
      .clk(clk), .rst(rst), .bus(bus[g])
    );
    assign obs[g] = {bus[g].step, bus[g].dir, bus[g].err, bus[g].err_sticky, bus[g].state_ab};
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int res_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 2 : 1;
  endfunction

  // Position of an {A,B} code along the forward Gray cycle.
  function automatic int gpos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gab(input int p);
    logic [1:0] t [4];
    t = '{2'b00, 2'b10, 2'b11, 2'b01};
    return t[p % 4];
  endfunction

  function automatic bit counts(input int res, input int pp, input int pc);
    if (res == 4) return 1'b1;
    if (res == 2) return (pp / 2) == (pc / 2);
    return (pp + pc) == 1;
  endfunction

  // Reference model state
  logic [1:0] hist [64];
  int         m_cnt;
  logic [1:0] m_filt, m_prev;
  logic       m_dir, m_err, m_sticky;
  logic [NDUT-1:0] m_step;

  task automatic model_edge();
    int  d;
    bit  flip;
    if (rst) begin
      m_cnt = 0; m_filt = 2'b00; m_prev = 2'b00;
      m_dir = 1'b0; m_err = 1'b0; m_sticky = 1'b0; m_step = '0;
      return;
    end
    m_cnt++;
    hist[m_cnt % 64] = {a, b};
    m_step = '0;
    m_err  = 1'b0;
    if (m_cnt == 3) begin
      m_filt = hist[1];
      m_prev = hist[1];
    end else if (m_cnt >= 4) begin
      d = (gpos(m_filt) - gpos(m_prev) + 4) % 4;
      if (d == 2) m_err = 1'b1;
      else if (d != 0) begin
        m_dir = (d == 1);
        for (int i = 0; i < NDUT; i++)
          m_step[i] = en && counts(res_of(i), gpos(m_prev), gpos(m_filt));
      end
      m_prev = m_filt;
      // A channel flips once it has disagreed for FL counted cycles in a row.
      for (int ch = 0; ch < 2; ch++) begin
        flip = (m_cnt - FL + 1) >= 4;
        for (int m = m_cnt - FL + 1; m <= m_cnt; m++)
          if (flip && hist[(m - 2) % 64][ch] == m_filt[ch]) flip = 1'b0;
        if (flip) m_filt[ch] = ~m_filt[ch];
      end
    end
    if (m_err)        m_sticky = 1'b1;
    else if (err_clr) m_sticky = 1'b0;
  endtask

  int n_step [NDUT];
  int n_err;
  int lat;

  task automatic clr_cnt();
    for (int i = 0; i < NDUT; i++) n_step[i] = 0;
    n_err = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("cyc_x%0d", res_of(i)), 32'(obs[i]),
            32'({m_step[i], m_dir, m_err, m_sticky, m_filt}));
      n_step[i] += int'(obs[i][5]);
    end
    n_err += int'(obs[0][3]);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic move(input logic [1:0] ab, input int n);
    a = ab[1]; b = ab[0]; lat = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (lat < 0 && obs[0][5]) lat = i;
    end
  endtask

  initial begin
    logic [1:0] ab;
    int         r, idx;
    rst = 1'b1; en = 1'b1; a = 1'b0; b = 1'b0; err_clr = 1'b0;
    hold(2);
    check("rst_outs", 32'(obs[0]), 32'd0);
    rst = 1'b0;
    hold(12);
    check("init_ab", 32'(obs[0][1:0]), 32'd0);

    // Forward cycle, X4
    clr_cnt();
    move(2'b10, 10); check("fwd_lat1", lat, FL + 2);
    move(2'b11, 10); check("fwd_lat2", lat, FL + 2);
    move(2'b01, 10); check("fwd_lat3", lat, FL + 2);
    move(2'b00, 10); check("fwd_lat4", lat, FL + 2);
    check("fwd_steps", n_step[0], 4);
    check("fwd_err", n_err, 0);
    check("fwd_dir", 32'(obs[0][4]), 32'd1);

    // Reverse cycle
    clr_cnt();
    move(2'b01, 10); check("rev_ab1", 32'(obs[0][1:0]), 32'b01);
    move(2'b11, 10); check("rev_ab2", 32'(obs[0][1:0]), 32'b11);
    move(2'b10, 10); check("rev_ab3", 32'(obs[0][1:0]), 32'b10);
    move(2'b00, 10); check("rev_ab4", 32'(obs[0][1:0]), 32'b00);
    check("rev_steps", n_step[0], 4);
    check("rev_dir", 32'(obs[0][4]), 32'd0);

    // Glitch shorter than the filter, then one just long enough
    clr_cnt();
    move(2'b10, 3); move(2'b00, 10);
    check("glitch_steps", n_step[0], 0);
    check("glitch_ab", 32'(obs[0][1:0]), 32'b00);
    clr_cnt();
    move(2'b10, FL); move(2'b00, 6);
    check("min_pulse_steps", n_step[0], 1);
    check("min_pulse_dir", 32'(obs[0][4]), 32'd1);
    hold(12);

    // Illegal transition, sticky clear, clear coincident with a new error
    clr_cnt();
    move(2'b11, 12);
    check("ill_err_cycles", n_err, 1);
    check("ill_steps", n_step[0], 0);
    check("ill_sticky", 32'(obs[0][2]), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    check("clr_sticky", 32'(obs[0][2]), 32'd0);
    a = 1'b0; b = 1'b0;
    hold(FL + 2);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("coinc_err", 32'(obs[0][3]), 32'd1);
    check("coinc_sticky", 32'(obs[0][2]), 32'd1);
    hold(10);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Resolution comparison across the three instances
    clr_cnt();
    move(2'b10, 10); move(2'b11, 10); move(2'b01, 10); move(2'b00, 10);
    check("x4_fwd", n_step[0], 4);
    check("x2_fwd", n_step[1], 2);
    check("x1_fwd", n_step[2], 1);
    clr_cnt();
    move(2'b01, 10); move(2'b11, 10); move(2'b10, 10); move(2'b00, 10);
    check("x2_rev", n_step[1], 2);
    check("x1_rev", n_step[2], 1);
    check("x1_rev_dir", 32'(obs[2][4]), 32'd0);

    // Enable gating, then reset with pins high
    clr_cnt();
    en = 1'b0;
    move(2'b10, 10); move(2'b11, 10);
    check("dis_steps", n_step[0], 0);
    check("dis_dir", 32'(obs[0][4]), 32'd1);
    en = 1'b1;
    move(2'b01, 10);
    check("reen_steps", n_step[0], 1);
    a = 1'b1; b = 1'b1; rst = 1'b1;
    hold(2);
    check("rst11_x4", 32'(obs[0]), 32'd0);
    check("rst11_x1", 32'(obs[2]), 32'd0);
    rst = 1'b0;
    hold(3);
    check("rst11_ab", 32'(obs[0][1:0]), 32'b11);
    clr_cnt();
    hold(12);
    check("rst11_steps", n_step[0], 0);
    check("rst11_err", n_err, 0);

    // Randomised phase: legal steps, illegal jumps, glitches, enable, clears, resets
    for (int s = 0; s < 400; s++) begin
      ab  = {a, b};
      r   = $urandom_range(0, 99);
      idx = $urandom_range(0, 1);
      if (r < 60)      ab = gab(gpos(ab) + (($urandom_range(0, 1) != 0) ? 1 : 3));
      else if (r < 70) ab = ~ab;
      else             ab[idx] = ~ab[idx];
      a = ab[1]; b = ab[0];
      en      = ($urandom_range(0, 99) < 85);
      err_clr = ($urandom_range(0, 19) == 0);
      rst     = (r >= 98);
      for (int i = 0; i < int'($urandom_range(1, 3 * FL)); i++) begin
        tick();
        err_clr = 1'b0;
        rst     = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
